// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and constants for the two-port BurstRAM line arbiter.
package burst_ram_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StRdWait,
        StWrBeats,
        StDone
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_rr_arbiter.sv
// Two-way round-robin grant; on a tie the requester not served last wins.
module burst_ram_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic served,
    output logic grant_valid,
    output logic grant_id
);

    // Resets to 1 so requester 0 wins the first tie.
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served;
        end
    end

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_q;
        end else begin
            grant_id = req1;
        end
    end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Line-level front end for BurstRAM: arbitrates two requesters and runs one burst per request,
// gathering read beats into a line and splitting write lines into beats.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH_BITWIDTH     = 4,
    parameter int unsigned DATA_BITWIDTH      = 64,
    parameter int unsigned BURST_COUNT        = 4,
    parameter int unsigned LINE_ADDR_BITWIDTH = DEPTH_BITWIDTH - $clog2(BURST_COUNT)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   r0_valid,
    input  logic                                   r0_write,
    input  logic [LINE_ADDR_BITWIDTH-1:0]          r0_addr,
    input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]   r0_wdata,
    output logic                                   r0_ready,
    output logic                                   r0_done,
    input  logic                                   r1_valid,
    input  logic                                   r1_write,
    input  logic [LINE_ADDR_BITWIDTH-1:0]          r1_addr,
    input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]   r1_wdata,
    output logic                                   r1_ready,
    output logic                                   r1_done,
    output logic [DATA_BITWIDTH*BURST_COUNT-1:0]   rdata,
    output logic                                   cmd,
    output logic                                   cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]              addr,
    output logic [DATA_BITWIDTH-1:0]               wr_data,
    output logic [DATA_BITWIDTH/8-1:0]             data_mask,
    input  logic [DATA_BITWIDTH-1:0]               rd_data,
    input  logic                                   rd_data_valid,
    input  logic                                   busy
);

    localparam int unsigned LINE_W = DATA_BITWIDTH * BURST_COUNT;
    localparam int unsigned BEAT_W = $clog2(BURST_COUNT);
    localparam logic [BEAT_W:0]   BEATS_ALL = (BEAT_W + 1)'(BURST_COUNT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_COUNT - 1);

    state_e                        state_q;
    logic [BEAT_W:0]               beat_q;
    logic [BEAT_W-1:0]             beat_idx;
    logic                          write_q;
    logic                          owner_q;
    logic [LINE_ADDR_BITWIDTH-1:0] line_addr_q;
    logic [LINE_W-1:0]             wline_q;
    logic [LINE_W-1:0]             rline_q;
    logic                          grant_valid;
    logic                          grant_id;

    assign beat_idx  = beat_q[BEAT_W-1:0];
    assign data_mask = '0;

    burst_ram_rr_arbiter u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req0        (r0_valid),
        .req1        (r1_valid),
        .update      (state_q == StDone),
        .served      (owner_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            write_q     <= 1'b0;
            owner_q     <= 1'b0;
            line_addr_q <= '0;
            wline_q     <= '0;
            rline_q     <= '0;
            rdata       <= '0;
            cmd         <= CMD_READ;
            cmd_en      <= 1'b0;
            addr        <= '0;
            wr_data     <= '0;
            r0_ready    <= 1'b0;
            r1_ready    <= 1'b0;
            r0_done     <= 1'b0;
            r1_done     <= 1'b0;
        end else begin
            r0_ready <= 1'b0;
            r1_ready <= 1'b0;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!busy && grant_valid) begin
                        owner_q <= grant_id;
                        if (grant_id) begin
                            r1_ready    <= 1'b1;
                            write_q     <= r1_write;
                            line_addr_q <= r1_addr;
                            wline_q     <= r1_wdata;
                        end else begin
                            r0_ready    <= 1'b1;
                            write_q     <= r0_write;
                            line_addr_q <= r0_addr;
                            wline_q     <= r0_wdata;
                        end
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    cmd_en <= 1'b1;
                    cmd    <= write_q ? CMD_WRITE : CMD_READ;
                    addr   <= {line_addr_q, {BEAT_W{1'b0}}};
                    if (write_q) begin
                        wr_data <= wline_q[DATA_BITWIDTH-1:0];
                        beat_q  <= (BEAT_W + 1)'(1);
                        state_q <= StWrBeats;
                    end else begin
                        beat_q  <= '0;
                        state_q <= StRdWait;
                    end
                end
                StWrBeats: begin
                    cmd_en <= 1'b0;
                    // beat_q reaches BURST_COUNT one cycle after the last beat is driven.
                    if (beat_q == BEATS_ALL) begin
                        r0_done <= ~owner_q;
                        r1_done <= owner_q;
                        state_q <= StDone;
                    end else begin
                        wr_data <= wline_q[int'(beat_idx) * DATA_BITWIDTH +: DATA_BITWIDTH];
                        beat_q  <= beat_q + 1'b1;
                    end
                end
                StRdWait: begin
                    cmd_en <= 1'b0;
                    if (rd_data_valid) begin
                        rline_q[int'(beat_idx) * DATA_BITWIDTH +: DATA_BITWIDTH] <= rd_data;
                        beat_q <= beat_q + 1'b1;
                        if (beat_idx == BEAT_LAST) begin
                            rdata   <= {rd_data, rline_q[LINE_W-DATA_BITWIDTH-1:0]};
                            r0_done <= ~owner_q;
                            r1_done <= owner_q;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Scoreboard bench for burst_ram_arbiter with a behavioural BurstRAM (4-cycle read latency).
module tb_burst_ram_arbiter;

    localparam logic [255:0] LINE0 = {64'h7D4E9F2C1B6A3D8F, 64'hA1C3F7E2D5B8A9C4,
                                      64'h9D8E2F17AB4C3E6F, 64'h3F5A2E14B7C6A980};
    localparam logic [255:0] LINE1 = {64'hD4E7F2C5B8A3D6E9, 64'hF8E9D2C3B4A5F6E7,
                                      64'hE1A7D0B5C8F3E6A9, 64'h6C4B9A8D2F5E3C7A};
    localparam logic [255:0] LINE2 = {64'h4444444444444444, 64'h3333333333333333,
                                      64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] LINE3 = {64'h8888888888888888, 64'h7777777777777777,
                                      64'h6666666666666666, 64'h5555555555555555};

    logic         clk = 1'b0;
    logic         rst;
    logic         r0_valid, r0_write, r0_ready, r0_done;
    logic [1:0]   r0_addr;
    logic [255:0] r0_wdata;
    logic         r1_valid, r1_write, r1_ready, r1_done;
    logic [1:0]   r1_addr;
    logic [255:0] r1_wdata;
    logic [255:0] rdata;
    logic         cmd, cmd_en;
    logic [3:0]   addr;
    logic [63:0]  wr_data;
    logic [7:0]   data_mask;
    logic [63:0]  rd_data;
    logic         rd_data_valid;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_cmd = 1'b1;

    typedef struct packed {
        logic         rd;
        logic [255:0] data;
    } exp_t;

    int          rdy_q[$];
    logic [4:0]  cmd_q[$];
    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [63:0] wb_q[$];

    always #5 clk = ~clk;

    burst_ram_arbiter #(
        .DEPTH_BITWIDTH (4),
        .DATA_BITWIDTH  (64),
        .BURST_COUNT    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .r0_valid      (r0_valid),
        .r0_write      (r0_write),
        .r0_addr       (r0_addr),
        .r0_wdata      (r0_wdata),
        .r0_ready      (r0_ready),
        .r0_done       (r0_done),
        .r1_valid      (r1_valid),
        .r1_write      (r1_write),
        .r1_addr       (r1_addr),
        .r1_wdata      (r1_wdata),
        .r1_ready      (r1_ready),
        .r1_done       (r1_done),
        .rdata         (rdata),
        .cmd           (cmd),
        .cmd_en        (cmd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .data_mask     (data_mask),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .busy          (busy)
    );

    // Behavioural BurstRAM: busy for 10 cycles after its own reset, first read beat 4 cycles
    // after cmd_en, write beat 0 alongside cmd_en and beats 1..3 on the following cycles.
    logic [63:0] mem [16];
    logic        ram_rst;
    int          init_cnt;
    logic        rd_active;
    int          rd_timer;
    logic [3:0]  rd_base;
    int          wr_cnt;
    logic [3:0]  wr_base;

    assign busy = (init_cnt != 0);

    always @(posedge clk) begin
        if (ram_rst) begin
            init_cnt      <= 10;
            rd_active     <= 1'b0;
            rd_timer      <= 0;
            rd_base       <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            wr_cnt        <= 0;
            wr_base       <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                mem[i]     <= LINE0[i*64 +: 64];
                mem[4 + i] <= LINE1[i*64 +: 64];
            end
        end else begin
            if (init_cnt != 0) init_cnt <= init_cnt - 1;
            rd_data_valid <= 1'b0;
            if (cmd_en && !cmd) begin
                rd_active <= 1'b1;
                rd_timer  <= 1;
                rd_base   <= addr;
            end else if (rd_active) begin
                if (rd_timer >= 3 && rd_timer <= 6) begin
                    rd_data_valid <= 1'b1;
                    rd_data       <= mem[rd_base + 4'(rd_timer - 3)];
                end
                rd_timer <= rd_timer + 1;
                if (rd_timer == 6) rd_active <= 1'b0;
            end
            if (cmd_en && cmd) begin
                mem[addr] <= wr_data;
                wr_cnt    <= 1;
                wr_base   <= addr;
            end else if (wr_cnt != 0) begin
                mem[wr_base + 4'(wr_cnt)] <= wr_data;
                wr_cnt <= (wr_cnt == 3) ? 0 : wr_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (r0_ready || r1_ready) begin
                if (rdy_q.size() == 0) begin
                    check("ready_unexpected", {r1_ready, r0_ready}, 2'b00);
                end else begin
                    int e;
                    e = rdy_q.pop_front();
                    check("ready_grant", {r1_ready, r0_ready}, (e == 1) ? 2'b10 : 2'b01);
                end
            end
            if (cmd_en && chk_cmd) begin
                if (cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
                else check("cmd_addr", {cmd, addr}, cmd_q.pop_front());
            end
            if (r0_done) begin
                if (sb0.size() == 0) begin
                    check("r0_done_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb0.pop_front();
                    if (e.rd) check("r0_rdata", rdata, e.data);
                end
            end
            if (r1_done) begin
                if (sb1.size() == 0) begin
                    check("r1_done_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb1.pop_front();
                    if (e.rd) check("r1_rdata", rdata, e.data);
                end
            end
            if ((cmd_en && cmd) || wr_cnt != 0) begin
                if (wb_q.size() == 0) check("wr_beat_unexpected", 1, 0);
                else check("wr_beat", wr_data, wb_q.pop_front());
                check("data_mask", data_mask, 0);
            end
        end
    end

    task automatic push_exp(input int id, input logic wr, input logic [1:0] la,
                            input logic [255:0] wd, input logic [255:0] erd, input bit push_rdy);
        exp_t e;
        if (push_rdy) rdy_q.push_back(id);
        if (chk_cmd) cmd_q.push_back({wr, la, 2'b00});
        e.rd   = ~wr;
        e.data = erd;
        if (id == 0) sb0.push_back(e);
        else sb1.push_back(e);
        if (wr) for (int b = 0; b < 4; b++) wb_q.push_back(wd[b*64 +: 64]);
    endtask

    task automatic drive_req(input int id, input logic wr, input logic [1:0] la,
                             input logic [255:0] wd);
        if (id == 0) begin
            r0_valid = 1'b1; r0_write = wr; r0_addr = la; r0_wdata = wd;
        end else begin
            r1_valid = 1'b1; r1_write = wr; r1_addr = la; r1_wdata = wd;
        end
    endtask

    task automatic wait_ready(input int id, output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            got = (id == 0) ? r0_ready : r1_ready;
        end
        if (!got) check("ready_timeout", 0, 1);
        if (id == 0) r0_valid = 1'b0;
        else r1_valid = 1'b0;
    endtask

    task automatic wait_done(input int id, output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            got = (id == 0) ? r0_done : r1_done;
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic do_req(input int id, input logic wr, input logic [1:0] la,
                          input logic [255:0] wd, input logic [255:0] erd, input bit push_rdy);
        int rl, dl;
        push_exp(id, wr, la, wd, erd, push_rdy);
        @(negedge clk);
        drive_req(id, wr, la, wd);
        wait_ready(id, rl);
        wait_done(id, dl);
        check(wr ? "write_done_latency" : "read_done_latency", dl, wr ? 5 : 9);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int viol, cyc, lat;
        r0_valid = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
        ram_rst = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {cmd, cmd_en, addr, wr_data, r0_ready, r1_ready, r0_done,
                                r1_done, rdata}, 0);
        rst = 1'b0;
        ram_rst = 1'b0;

        // RAM still initialising: a pending request must wait for busy to fall.
        push_exp(0, 1'b0, 2'd0, '0, LINE0, 1'b1);
        drive_req(0, 1'b0, 2'd0, '0);
        viol = 0;
        cyc = 0;
        while (busy && cyc < 50) begin
            @(negedge clk);
            if (r0_ready || r1_ready || cmd_en) viol++;
            cyc++;
        end
        check("busy_blocks_grant", viol, 0);
        wait_ready(0, lat);
        check("ready_after_busy_latency", lat, 1);
        wait_done(0, lat);
        check("read_done_latency", lat, 9);

        do_req(0, 1'b1, 2'd2, LINE2, '0, 1'b1);
        check("rdata_hold_after_write", rdata, LINE0);
        do_req(0, 1'b0, 2'd2, '0, LINE2, 1'b1);
        do_req(1, 1'b0, 2'd1, '0, LINE1, 1'b1);

        // Both requesters contend; requester 1 was served last, so r0 wins first.
        chk_cmd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rdy_q.push_back(0);
            rdy_q.push_back(1);
        end
        fork
            begin
                do_req(0, 1'b0, 2'd0, '0, LINE0, 1'b0);
                do_req(0, 1'b1, 2'd3, LINE3, '0, 1'b0);
                do_req(0, 1'b0, 2'd3, '0, LINE3, 1'b0);
            end
            begin
                do_req(1, 1'b0, 2'd1, '0, LINE1, 1'b0);
                do_req(1, 1'b0, 2'd2, '0, LINE2, 1'b0);
                do_req(1, 1'b0, 2'd1, '0, LINE1, 1'b0);
            end
        join
        chk_cmd = 1'b1;
        check("contention_grants_consumed", rdy_q.size(), 0);

        // Reset in the middle of a read burst abandons it.
        rdy_q.push_back(1);
        cmd_q.push_back({1'b0, 2'd1, 2'b00});
        @(negedge clk);
        drive_req(1, 1'b0, 2'd1, '0);
        wait_ready(1, lat);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midburst_rst_ctrl", {cmd, cmd_en, addr, data_mask, r0_ready, r1_ready, r0_done,
                                    r1_done}, 0);
        check("midburst_rst_wr_data", wr_data, 0);
        check("midburst_rst_rdata", rdata, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_done_after_abort", sb1.size(), 0);
        do_req(1, 1'b0, 2'd0, '0, LINE0, 1'b1);

        repeat (3) @(negedge clk);
        check("sb0_empty", sb0.size(), 0);
        check("sb1_empty", sb1.size(), 0);
        check("ready_q_empty", rdy_q.size(), 0);
        check("cmd_q_empty", cmd_q.size(), 0);
        check("wr_beat_q_empty", wb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
